// File: rtl/net_result_collector.sv
// Captures net outputs on each rising done, classifies lanes vs THRESH,
// queues {y, class} for a valid/ready consumer. Stats: NET_COLLECT_STATS_EN.
module net_result_collector #(
  parameter int          O      = 1,
  parameter int          DEPTH  = 4,
  parameter logic [31:0] THRESH = 32'h3F000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         done,
  input  logic [32*O-1:0]              y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [32*O-1:0]              out_y,
  output logic [O-1:0]                 out_class,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
`ifdef NET_COLLECT_STATS_EN
  ,
  output logic [15:0]                  total_cnt,
  output logic [15:0]                  pos_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // strict IEEE greater-than against THRESH; NaN never exceeds
  function automatic logic gt_thresh(input logic [31:0] a);
    logic [31:0] t;
    logic a_nan, t_nan, a_zero, t_zero, r;
    t      = THRESH;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    t_nan  = (t[30:23] == 8'hFF) && (t[22:0] != 23'd0);
    a_zero = (a[30:0] == 31'd0);
    t_zero = (t[30:0] == 31'd0);
    r      = 1'b0;
    priority case (1'b1)
      a_nan | t_nan:       r = 1'b0;
      a_zero & t_zero:     r = 1'b0;
      ~a[31] & ~t[31]:     r = a[30:0] > t[30:0];
      a[31] & ~t[31]:      r = 1'b0;
      ~a[31] & t[31]:      r = 1'b1;
      default:             r = a[30:0] < t[30:0];
    endcase
    return r;
  endfunction

  logic [32*O-1:0] mem_y [DEPTH];
  logic [O-1:0]    mem_c [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            done_q;
  logic            push;
  logic            pop;
  logic            full;
  logic            accept;
  logic [O-1:0]    cls;

  always_comb begin
    cls = '0;
    for (int i = 0; i < O; i++) begin
      cls[i] = gt_thresh(y[32*i +: 32]);
    end
  end

  assign push      = done & ~done_q;
  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = out_valid & out_ready;
  // a pop in the same cycle frees the slot the push needs
  assign accept    = push & (~full | pop);
  assign out_y     = out_valid ? mem_y[rd_ptr] : '0;
  assign out_class = out_valid ? mem_c[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_y[i] <= '0;
        mem_c[i] <= '0;
      end
    end else begin
      done_q <= done;
      if (accept) begin
        mem_y[wr_ptr] <= y;
        mem_c[wr_ptr] <= cls;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !accept) begin
        overflow <= 1'b1;
      end
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef NET_COLLECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cnt <= '0;
      pos_cnt   <= '0;
    end else if (accept) begin
      if (total_cnt != 16'hFFFF) begin
        total_cnt <= total_cnt + 1'b1;
      end
      if (cls[0] && pos_cnt != 16'hFFFF) begin
        pos_cnt <= pos_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_net_result_collector.sv
// Directed bench for net_result_collector (O=1, DEPTH=4, THRESH=0.5).
// Inputs change 1ns after posedge; outputs are checked there too.
module tb_net_result_collector;

  logic        clk;
  logic        rst_n;
  logic        done;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [0:0]  out_class;
  logic [2:0]  count;
  logic        overflow;
`ifdef NET_COLLECT_STATS_EN
  logic [15:0] total_cnt;
  logic [15:0] pos_cnt;
`endif

  int checks = 0;
  int errors = 0;

  net_result_collector #(
    .O(1),
    .DEPTH(4),
    .THRESH(32'h3F000000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .done(done),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y(out_y),
    .out_class(out_class),
    .count(count),
    .overflow(overflow)
`ifdef NET_COLLECT_STATS_EN
    ,
    .total_cnt(total_cnt),
    .pos_cnt(pos_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    done  = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [31:0] v);
    y    = v;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  logic [31:0] seq_y [6];
  logic        seq_c [6];
  logic [31:0] flt   [5];

  initial begin
    seq_y = '{32'h3C000000, 32'h3F000000, 32'h7FC00000,
              32'h80000000, 32'hBF800000, 32'h7F800000};
    seq_c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    flt   = '{32'h3F800000, 32'h40000000, 32'h40400000,
              32'h40800000, 32'h40A00000};

    rst_n     = 1'b0;
    done      = 1'b0;
    y         = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_y", out_y, 32'd0);
    chk("rst_class", {31'd0, out_class}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single capture, latency 1 clk, then popped
    out_ready = 1'b1;
    y    = 32'h3F7F0000;
    done = 1'b1;
    tick();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_y", out_y, 32'h3F7F0000);
    chk("t1_class", {31'd0, out_class}, 32'd1);
    done = 1'b0;
    tick();
    chk("t1_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t1_count_after", {29'd0, count}, 32'd0);

    // classification corner cases
    for (int i = 0; i < 6; i++) begin
      y    = seq_y[i];
      done = 1'b1;
      tick();
      chk($sformatf("cls_y%0d", i), out_y, seq_y[i]);
      chk($sformatf("cls_c%0d", i), {31'd0, out_class},
          {31'd0, seq_c[i]});
      done = 1'b0;
      tick();
    end

    // fill past full with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pulse(flt[i]);
    chk("ovf_count", {29'd0, count}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_y%0d", i), out_y, flt[i]);
      chk($sformatf("drain_c%0d", i), {31'd0, out_class}, 32'd1);
      tick();
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // push and pop together while full
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(flt[i]);
    chk("pp_full", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    y    = flt[4];
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("pp_count", {29'd0, count}, 32'd4);
    chk("pp_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("pp_y%0d", i), out_y, flt[i]);
      tick();
    end
    chk("pp_empty", {29'd0, count}, 32'd0);

    // held done gives one push; async reset mid-operation
    out_ready = 1'b0;
    y    = 32'h3F800000;
    done = 1'b1;
    repeat (10) tick();
    chk("hold_count", {29'd0, count}, 32'd1);
    done = 1'b0; tick();
    done = 1'b1; tick();
    done = 1'b0; tick();
    done = 1'b1; tick();
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_count", {29'd0, count}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_nocap", {29'd0, count}, 32'd0);
    done = 1'b0; tick();
    done = 1'b1; tick();
    chk("post_rst_cap", {29'd0, count}, 32'd1);
    done = 1'b0;
    tick();

`ifdef NET_COLLECT_STATS_EN
    do_reset();
    chk("st_rst_total", {16'd0, total_cnt}, 32'd0);
    out_ready = 1'b0;
    pulse(32'h00000000);
    pulse(32'h3F800000);
    pulse(32'h3F800000);
    pulse(32'h00000000);
    pulse(32'h3F800000);
    chk("st_ovf", {31'd0, overflow}, 32'd1);
    chk("st_total", {16'd0, total_cnt}, 32'd4);
    chk("st_pos", {16'd0, pos_cnt}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/net_result_collector.md
Name: net_result_collector

Overview:
- Downstream stage of `net`: captures the packed IEEE-754 single-precision output vector `y` on each rising edge of `done`.
- Classifies every output lane against a float threshold and buffers {y, class} in a small FIFO.
- Presents the buffered results on a valid/ready interface so the host or scoreboard can drain them at its own pace.
- Decouples inference completion from result consumption; `net` never stalls.

Parameters:
- O, 1, number of 32-bit output lanes (matches `net` O).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- THRESH, 32'h3F000000, IEEE-754 threshold (0.5); class bit = (lane > THRESH).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  reset; asynchronous, active-low.
- done  input  1  `net` completion flag; level may stay high for many cycles.
- y  input  32*O  `net` output vector, lane i at bits [32*i+31:32*i]; valid whenever done=1.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head this cycle.
- out_y  output  32*O  head entry's captured y.
- out_class  output  O  head entry's class bits, bit i for lane i.
- count  output  $clog2(DEPTH+1)  current occupancy.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.

Behaviour:
- Reset, asynchronous: done_q=1, FIFO empty, rd/wr pointers 0, count=0, out_valid=0, out_y=0, out_class=0, overflow=0.
  - done_q resets to 1 so a done already high at reset release is not captured.
- Edge detect: push = done & ~done_q, sampled at posedge. done_q <= done every cycle. A done held high for N cycles produces exactly one push.
- Push writes {y, class(y)} at wr_ptr on the same posedge.
  - out_valid/out_y/out_class reflect the new head from the next cycle. Latency is 1 clk from the sampled rising edge to out_valid.
- Pop = out_valid & out_ready; the head advances on that posedge.
- out_y/out_class are driven from the head entry (registered storage). They are 0 when empty.
- Simultaneous push and pop:
  - Not full: both happen, count unchanged.
  - Full: the pop frees a slot, so the push is accepted and count stays DEPTH. overflow is not set.
- Push while full without pop: entry dropped, overflow <= 1, FIFO contents untouched. overflow clears only on reset.
- Pop while empty: impossible, since out_valid=0. out_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from count, not pointer equality.
- Classification per lane (combinational at capture). Let s=bit31, e=bits30:23, m=bits22:0.
  - NaN (e=8'hFF, m≠0) → 0.
  - ±0 are equal; neither exceeds THRESH=+0.
  - Both non-negative: greater iff unsigned bits[30:0] of lane > THRESH[30:0].
  - Lane negative, THRESH non-negative: 0.
  - Lane non-negative, THRESH negative: 1, unless both are zero.
  - Both negative: greater iff lane[30:0] < THRESH[30:0].
  - ±Inf compare by the rules above. Equality → 0 (strict greater-than).
- Reset mid-operation (any occupancy, done high or low) returns all state to reset values immediately. No further push until done falls and rises again.

Optional Feature:
- Macro NET_COLLECT_STATS_EN.
- Defined:
  - Adds output ports total_cnt[15:0] and pos_cnt[15:0], both reset to 0.
  - total_cnt increments on every accepted push.
  - pos_cnt increments on an accepted push whose lane-0 class bit is 1.
  - Both counters saturate at 16'hFFFF.
  - Dropped (overflow) captures are not counted.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- O=1, out_ready=1, y=32'h3F7F0000 (≈0.996), done pulsed 1 cycle → out_valid high 1 clk later with out_y=3F7F0000, out_class=1. Next cycle out_valid=0, count=0.
- y sequence 3C000000, 3F000000, 7FC00000 (NaN), 80000000 (−0), BF800000 (−1.0), 7F800000 (+Inf), out_ready=1 → class 0,0,0,0,0,1, in order.
- out_ready=0, 5 done pulses with y=1,2,3,4,5 (as floats), DEPTH=4 → count=4, overflow=1. Draining yields 1,2,3,4 then out_valid=0.
- FIFO full, out_ready=1 and a done rising edge in the same cycle → count stays 4, overflow stays 0, new entry later appears last.
- done held high 10 cycles → count=1. rst_n low at count=3 with done high → count=0, out_valid=0, overflow=0; no capture after release until done toggles 0→1.
- NET_COLLECT_STATS_EN defined, XOR sequence class 0,1,1,0 plus 1 dropped push → total_cnt=4, pos_cnt=2.
